// File: rtl/coord_pkg.sv
// coord_pkg: shared types and constants for the coord_mapper slice.
//   fixed_t      : default-width signed fixed-point coordinate type
//   state_t      : frame sequencer states (IDLE/LOAD/RUN/DONE)
//   COORD_*      : default format widths (Q5.20 coordinates, 10-bit pixel counters)
//   DEFAULT_STEP : 0.003125 per pixel in Q5.20 (3276.8 rounded to 3277)
package coord_pkg;

  localparam int COORD_DATA_W  = 25;
  localparam int COORD_FRACT_W = 20;
  localparam int COORD_PIXEL_W = 10;

  typedef logic signed [COORD_DATA_W-1:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam fixed_t DEFAULT_STEP = 25'sd3277;
  localparam fixed_t FIXED_ONE    = 25'sd1048576;

endpackage

// File: rtl/coord_mapper_if.sv
// coord_mapper_if: beat stream from the coordinate generator to the engine distributor.
//   out_valid  : beat available (producer)
//   out_ready  : consumer accepts the beat
//   real_x     : LANES packed real coordinates, lane k at [k*DATA_W +: DATA_W]
//   imag_y     : imaginary coordinate shared by all lanes
//   pixel_x    : x of lane 0;  pixel_y : line index
//   last_x     : final beat of the line;  last_frame : final beat of the frame
// Modports: master = producer (coord_mapper), slave = consumer.
interface coord_mapper_if
  import coord_pkg::*;
#(
  parameter int DATA_W  = COORD_DATA_W,
  parameter int PIXEL_W = COORD_PIXEL_W,
  parameter int LANES   = 1
);

  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   real_x;
  logic [DATA_W-1:0]         imag_y;
  logic [PIXEL_W-1:0]        pixel_x;
  logic [PIXEL_W-1:0]        pixel_y;
  logic                      last_x;
  logic                      last_frame;

  modport master (
    output out_valid, real_x, imag_y, pixel_x, pixel_y, last_x, last_frame,
    input  out_ready
  );

  modport slave (
    input  out_valid, real_x, imag_y, pixel_x, pixel_y, last_x, last_frame,
    output out_ready
  );

endinterface

// File: rtl/coord_axis_acc.sv
// coord_axis_acc: one-axis coordinate accumulator.
//   clk, reset : clock, synchronous active-high reset (accumulator clears to 0)
//   restart    : reload the accumulator with base (takes priority over advance)
//   advance    : add inc to the accumulator (two's complement wraparound)
//   base, inc  : reload value and per-step increment
//   acc_next   : value the accumulator takes at the next edge; the parent registers
//                its outputs from this so they line up with the accumulator itself
module coord_axis_acc
  import coord_pkg::*;
#(
  parameter int DATA_W = COORD_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  input  logic                     advance,
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W-1:0] inc,
  output logic signed [DATA_W-1:0] acc_next
);

  logic signed [DATA_W-1:0] acc_r;
  logic signed [DATA_W-1:0] acc_next_s;

  // next accumulator value: restart beats advance, otherwise hold
  always_comb begin
    acc_next_s = acc_r;
    if (restart) begin
      acc_next_s = base;
    end else if (advance) begin
      acc_next_s = acc_r + inc;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= {DATA_W{1'b0}};
    end else begin
      acc_r <= acc_next_s;
    end
  end

  assign acc_next = acc_next_s;

endmodule

// File: rtl/coord_mapper.sv
// coord_mapper: scans a H_RES x V_RES frame and emits LANES adjacent pixels per beat
// with their fixed-point complex-plane coordinates (offset + index*step).
//   clk, reset           : clock, synchronous active-high reset
//   start                : frame request, only looked at in IDLE
//   step                 : per-pixel increment, both axes
//   x_offset, y_offset   : origin (top-left corner, or frame centre when
//                          COORD_MAPPER_CENTER_EN is defined)
//   busy                 : high in LOAD, RUN and DONE
//   frame_done           : one-cycle pulse in DONE
//   out_if (master)      : beat stream, see coord_mapper_if
// Optional build macro: COORD_MAPPER_CENTER_EN.
// Configuration is captured into shadow registers on the start cycle so a frame
// is immune to input changes. All outputs come straight from registers.
module coord_mapper
  import coord_pkg::*;
#(
  parameter int PIXEL_W = COORD_PIXEL_W,
  parameter int DATA_W  = COORD_DATA_W,
  parameter int FRACT_W = COORD_FRACT_W,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int LANES   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] step,
  input  logic signed [DATA_W-1:0] x_offset,
  input  logic signed [DATA_W-1:0] y_offset,
  output logic                     busy,
  output logic                     frame_done,
  coord_mapper_if.master           out_if
);

  localparam logic [PIXEL_W-1:0] LAST_X_C = PIXEL_W'(H_RES - LANES);
  localparam logic [PIXEL_W-1:0] LAST_Y_C = PIXEL_W'(V_RES - 1);
  localparam logic [PIXEL_W-1:0] LANES_C  = PIXEL_W'(LANES);

  // reject parameter sets the datapath cannot represent
  generate
    if ((FRACT_W >= DATA_W) || ((H_RES % LANES) != 0)) begin : g_bad_cfg
      $error("coord_mapper: invalid parameterisation");
    end
  endgenerate

  state_t state_r, next_state_s;
  logic   capture_s, load_s, accept_s, line_end_s;

  logic signed [DATA_W-1:0] step_sh_r, xoff_sh_r, yoff_sh_r;
  logic signed [DATA_W-1:0] x_start_s, y_start_s, x_start_r, y_start_r;
  logic signed [DATA_W-1:0] x_base_s, x_inc_s, x_next_s, y_next_s;
  logic signed [DATA_W-1:0] lane_off_s [LANES];
  logic signed [DATA_W-1:0] lane_off_r [LANES];
  logic signed [DATA_W-1:0] lane_sel_s [LANES];
  logic signed [DATA_W-1:0] real_x_r   [LANES];
  logic signed [DATA_W-1:0] imag_y_r;

  logic [PIXEL_W-1:0] pixel_x_r, pixel_y_r, px_next_s, py_next_s;
  logic               last_x_r, last_frame_r, last_x_next_s, last_frame_next_s;
  logic               out_valid_r, busy_r, frame_done_r;

  assign accept_s   = out_valid_r && out_if.out_ready;
  assign line_end_s = accept_s && last_x_r;

  // sequencer next state and one-cycle strobes
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = LOAD;
          capture_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        next_state_s = RUN;
        load_s       = 1'b1;
      end
      RUN: begin
        if (accept_s && last_frame_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // state register and status outputs, registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s != IDLE);
      frame_done_r <= (next_state_s == DONE);
      out_valid_r  <= (next_state_s == RUN);
    end
  end

  // shadow copy of the frame configuration, taken on the start cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      step_sh_r <= {DATA_W{1'b0}};
      xoff_sh_r <= {DATA_W{1'b0}};
      yoff_sh_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      step_sh_r <= step;
      xoff_sh_r <= x_offset;
      yoff_sh_r <= y_offset;
    end else begin
      step_sh_r <= step_sh_r;
      xoff_sh_r <= xoff_sh_r;
      yoff_sh_r <= yoff_sh_r;
    end
  end

  // lane offsets, x increment and frame start points (products truncate to DATA_W)
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_off_s[k] = step_sh_r * $signed(DATA_W'(k));
    end
    x_inc_s = step_sh_r * $signed(DATA_W'(LANES));
`ifdef COORD_MAPPER_CENTER_EN
    x_start_s = xoff_sh_r - step_sh_r * $signed(DATA_W'(H_RES / 2));
    y_start_s = yoff_sh_r - step_sh_r * $signed(DATA_W'(V_RES / 2));
`else
    x_start_s = xoff_sh_r;
    y_start_s = yoff_sh_r;
`endif
  end

  // during LOAD the registered copies are not valid yet, so use the fresh values
  always_comb begin
    x_base_s = x_start_r;
    for (int k = 0; k < LANES; k++) begin
      lane_sel_s[k] = lane_off_r[k];
    end
    if (load_s) begin
      x_base_s = x_start_s;
      for (int k = 0; k < LANES; k++) begin
        lane_sel_s[k] = lane_off_s[k];
      end
    end else begin
      x_base_s = x_start_r;
    end
  end

  coord_axis_acc #(.DATA_W(DATA_W)) u_x_acc (
    .clk      (clk),
    .reset    (reset),
    .restart  (load_s || line_end_s),
    .advance  (accept_s),
    .base     (x_base_s),
    .inc      (x_inc_s),
    .acc_next (x_next_s)
  );

  coord_axis_acc #(.DATA_W(DATA_W)) u_y_acc (
    .clk      (clk),
    .reset    (reset),
    .restart  (load_s),
    .advance  (line_end_s),
    .base     (y_start_s),
    .inc      (step_sh_r),
    .acc_next (y_next_s)
  );

  // pixel counters and end-of-line / end-of-frame flags for the next beat
  always_comb begin
    px_next_s = pixel_x_r;
    py_next_s = pixel_y_r;
    if (load_s) begin
      px_next_s = {PIXEL_W{1'b0}};
      py_next_s = {PIXEL_W{1'b0}};
    end else if (line_end_s) begin
      px_next_s = {PIXEL_W{1'b0}};
      py_next_s = pixel_y_r + {{(PIXEL_W-1){1'b0}}, 1'b1};
    end else if (accept_s) begin
      px_next_s = pixel_x_r + LANES_C;
    end else begin
      px_next_s = pixel_x_r;
      py_next_s = pixel_y_r;
    end
    last_x_next_s     = (px_next_s == LAST_X_C);
    last_frame_next_s = last_x_next_s && (py_next_s == LAST_Y_C);
  end

  // per-frame constants latched in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      x_start_r <= {DATA_W{1'b0}};
      y_start_r <= {DATA_W{1'b0}};
      for (int k = 0; k < LANES; k++) begin
        lane_off_r[k] <= {DATA_W{1'b0}};
      end
    end else if (load_s) begin
      x_start_r <= x_start_s;
      y_start_r <= y_start_s;
      for (int k = 0; k < LANES; k++) begin
        lane_off_r[k] <= lane_off_s[k];
      end
    end else begin
      x_start_r <= x_start_r;
      y_start_r <= y_start_r;
    end
  end

  // output beat registers: refreshed on LOAD and on every acceptance, held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      imag_y_r     <= {DATA_W{1'b0}};
      pixel_x_r    <= {PIXEL_W{1'b0}};
      pixel_y_r    <= {PIXEL_W{1'b0}};
      last_x_r     <= 1'b0;
      last_frame_r <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        real_x_r[k] <= {DATA_W{1'b0}};
      end
    end else if (load_s || accept_s) begin
      imag_y_r     <= y_next_s;
      pixel_x_r    <= px_next_s;
      pixel_y_r    <= py_next_s;
      last_x_r     <= last_x_next_s;
      last_frame_r <= last_frame_next_s;
      for (int k = 0; k < LANES; k++) begin
        real_x_r[k] <= x_next_s + lane_sel_s[k];
      end
    end else begin
      imag_y_r     <= imag_y_r;
      pixel_x_r    <= pixel_x_r;
      pixel_y_r    <= pixel_y_r;
      last_x_r     <= last_x_r;
      last_frame_r <= last_frame_r;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      assign out_if.real_x[g*DATA_W +: DATA_W] = real_x_r[g];
    end
  endgenerate

  assign out_if.out_valid  = out_valid_r;
  assign out_if.imag_y     = imag_y_r;
  assign out_if.pixel_x    = pixel_x_r;
  assign out_if.pixel_y    = pixel_y_r;
  assign out_if.last_x     = last_x_r;
  assign out_if.last_frame = last_frame_r;
  assign busy              = busy_r;
  assign frame_done        = frame_done_r;

endmodule

// File: tb/tb_coord_mapper.sv
// tb_coord_mapper: directed self-checking bench for coord_mapper at H_RES=8,
// V_RES=4, LANES=2 (16 beats per frame). Build with +define+COORD_MAPPER_CENTER_EN
// to exercise the centred-origin variant.
module tb_coord_mapper;
  import coord_pkg::*;

  localparam int DW = 25;
  localparam int PW = 10;
  localparam int HR = 8;
  localparam int VR = 4;
  localparam int LN = 2;
  localparam int NB = HR * VR / LN;
  localparam int BW = LN*DW + DW + PW + PW + 2;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   start = 1'b0;
  fixed_t step = 25'sd0;
  fixed_t x_offset = 25'sd0;
  fixed_t y_offset = 25'sd0;
  logic   busy, frame_done;

  coord_mapper_if #(.DATA_W(DW), .PIXEL_W(PW), .LANES(LN)) bus ();

  coord_mapper #(
    .PIXEL_W(PW), .DATA_W(DW), .FRACT_W(20), .H_RES(HR), .V_RES(VR), .LANES(LN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .x_offset(x_offset), .y_offset(y_offset),
    .busy(busy), .frame_done(frame_done), .out_if(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] rec [0:31];
  int n_rec, done_cyc, stall_viol;
  bit aborted;

  // offset + idx*step in DW-bit wraparound (idx may be negative)
  function automatic logic [DW-1:0] ref_coord(input logic [DW-1:0] off, input int idx,
                                              input logic [DW-1:0] stp);
    logic [DW-1:0] i_v;
    i_v = DW'(idx);
    return off + i_v * stp;
  endfunction

  // expected packed beat {real_x, imag_y, pixel_x, pixel_y, last_x, last_frame}
  function automatic logic [BW-1:0] exp_beat(input int b, input logic [DW-1:0] xo,
                                             input logic [DW-1:0] yo, input logic [DW-1:0] st);
    logic [LN*DW-1:0] r;
    logic [DW-1:0]    im;
    logic             lx, lf;
    int px, py, xs, ys;
`ifdef COORD_MAPPER_CENTER_EN
    xs = HR / 2; ys = VR / 2;
`else
    xs = 0; ys = 0;
`endif
    px = (b % (HR / LN)) * LN;
    py = b / (HR / LN);
    for (int k = 0; k < LN; k++) r[k*DW +: DW] = ref_coord(xo, px + k - xs, st);
    im = ref_coord(yo, py - ys, st);
    lx = (px == HR - LN);
    lf = lx && (py == VR - 1);
    return {r, im, PW'(px), PW'(py), lx, lf};
  endfunction

  function automatic logic [BW-1:0] snap();
    return {bus.real_x, bus.imag_y, bus.pixel_x, bus.pixel_y, bus.last_x, bus.last_frame};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // drives out_ready and records accepted beats; cyc 1 is the LOAD cycle
  // mode 0: ready high, 1: pseudo-random ready, 2: ready high plus input disturbances
  task automatic collect(input int mode, input int abort_at);
    logic [BW-1:0] prev;
    bit stalled;
    int cyc;
    stalled = 1'b0; cyc = 1; prev = '0;
    n_rec = 0; done_cyc = -1; stall_viol = 0; aborted = 1'b0;
    while (cyc < 400 && done_cyc < 0 && !aborted) begin
      if (stalled && (!bus.out_valid || snap() !== prev)) stall_viol++;
      if (frame_done) done_cyc = cyc;
      if (mode == 2) begin
        if (cyc == 2) begin
          step = 25'sd0;
          x_offset = 25'sd0;
        end
        start = (cyc == 5 || cyc == 9 || cyc == 18);
      end
      if (abort_at >= 0 && bus.out_valid && n_rec == abort_at) begin
        reset = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        if (mode == 1) bus.out_ready = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        else           bus.out_ready = 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          if (n_rec < 32) rec[n_rec] = snap();
          n_rec++;
        end
        stalled = bus.out_valid && !bus.out_ready;
        prev = snap();
        tick();
        cyc++;
      end
    end
    bus.out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic set_cfg(input fixed_t st, input fixed_t xo, input fixed_t yo);
    step = st; x_offset = xo; y_offset = yo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({bus.out_valid, busy, frame_done, snap()} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got v=%b busy=%b fd=%b data=%h, want all 0",
                 c, bus.out_valid, busy, frame_done, snap());
      end
      tick();
    end
  endtask

  task automatic test_corner_frame();
    logic [LN*DW-1:0] r0;
    fixed_t l0, l1;
    set_cfg(25'sd262144, -25'sd2097152, -25'sd1048576);
    kick();
    collect(0, -1);
    n_checks++;
    if (n_rec !== NB) begin n_fail++; $display("FAIL corner_count: got %0d want %0d", n_rec, NB); end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (rec[b] !== exp_beat(b, x_offset, y_offset, step)) begin
        n_fail++;
        $display("FAIL corner_beat%0d: got %h want %h", b, rec[b], exp_beat(b, x_offset, y_offset, step));
      end
    end
`ifndef COORD_MAPPER_CENTER_EN
    l0 = -25'sd2097152; l1 = -25'sd1835008;
    r0 = {l1, l0};
    n_checks++;
    if (rec[0][BW-1 -: LN*DW] !== r0 || rec[0][BW-LN*DW-1 -: DW] !== -25'sd1048576) begin
      n_fail++;
      $display("FAIL corner_beat0_hand: got real=%h imag=%h want real=%h imag=%h",
               rec[0][BW-1 -: LN*DW], rec[0][BW-LN*DW-1 -: DW], r0, -25'sd1048576);
    end
`endif
    n_checks++;
    if (rec[3][1] !== 1'b1 || rec[2][1] !== 1'b0) begin
      n_fail++; $display("FAIL corner_last_x: got b3=%b b2=%b want 1 0", rec[3][1], rec[2][1]);
    end
    n_checks++;
    if (rec[15][0] !== 1'b1 || rec[14][0] !== 1'b0) begin
      n_fail++; $display("FAIL corner_last_frame: got b15=%b b14=%b want 1 0", rec[15][0], rec[14][0]);
    end
    n_checks++;
    if (done_cyc !== 18) begin n_fail++; $display("FAIL corner_done_cycle: got %0d want 18", done_cyc); end
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL corner_after_done: got busy=%b fd=%b want 0 0", busy, frame_done);
    end
  endtask

  task automatic test_back_pressure();
    set_cfg(25'sd262144, -25'sd2097152, -25'sd1048576);
    kick();
    collect(1, -1);
    n_checks++;
    if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
    n_checks++;
    if (n_rec !== NB || done_cyc < 0) begin
      n_fail++; $display("FAIL bp_count: got %0d beats done=%0d want %0d beats and a frame_done", n_rec, done_cyc, NB);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (rec[b] !== exp_beat(b, x_offset, y_offset, step)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h want %h", b, rec[b], exp_beat(b, x_offset, y_offset, step));
      end
    end
  endtask

  task automatic test_shadowing();
    fixed_t st, xo, yo;
    st = 25'sd262144; xo = -25'sd2097152; yo = -25'sd1048576;
    set_cfg(st, xo, yo);
    kick();
    collect(2, -1);
    n_checks++;
    if (n_rec !== NB || done_cyc !== 18) begin
      n_fail++; $display("FAIL shadow_count: got %0d beats done_cyc=%0d want %0d and 18", n_rec, done_cyc, NB);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (rec[b] !== exp_beat(b, xo, yo, st)) begin
        n_fail++; $display("FAIL shadow_beat%0d: got %h want %h", b, rec[b], exp_beat(b, xo, yo, st));
      end
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL shadow_start_ignored cyc%0d: got busy=%b v=%b want 0 0", c, busy, bus.out_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    set_cfg(25'sd262144, -25'sd2097152, -25'sd1048576);
    kick();
    collect(0, 7);
    n_checks++;
    if (!aborted || n_rec !== 7) begin
      n_fail++; $display("FAIL midreset_reach: got aborted=%b beats=%0d want 1 7", aborted, n_rec);
    end
    n_checks++;
    if ({bus.out_valid, busy, frame_done, snap()} !== '0) begin
      n_fail++; $display("FAIL midreset_zero: got v=%b busy=%b fd=%b data=%h want all 0",
                         bus.out_valid, busy, frame_done, snap());
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL midreset_quiet cyc%0d: got fd=%b busy=%b want 0 0", c, frame_done, busy);
      end
      tick();
    end
    kick();
    collect(0, -1);
    n_checks++;
    if (n_rec !== NB || done_cyc !== 18) begin
      n_fail++; $display("FAIL replay_count: got %0d beats done_cyc=%0d want %0d and 18", n_rec, done_cyc, NB);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (rec[b] !== exp_beat(b, x_offset, y_offset, step)) begin
        n_fail++; $display("FAIL replay_beat%0d: got %h want %h", b, rec[b], exp_beat(b, x_offset, y_offset, step));
      end
    end
  endtask

  task automatic test_wrap();
    set_cfg(25'sh0FFFFFF, 25'sh0FFFFFF, 25'sd0);
    kick();
    collect(0, -1);
    n_checks++;
    if (n_rec !== NB) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", n_rec, NB); end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (rec[b] !== exp_beat(b, x_offset, y_offset, step)) begin
        n_fail++; $display("FAIL wrap_beat%0d: got %h want %h", b, rec[b], exp_beat(b, x_offset, y_offset, step));
      end
    end
`ifndef COORD_MAPPER_CENTER_EN
    n_checks++;
    if (rec[0][BW-1 -: DW] !== 25'h1FFFFFE) begin
      n_fail++; $display("FAIL wrap_lane1_hand: got %h want 1fffffe", rec[0][BW-1 -: DW]);
    end
`endif
  endtask

`ifdef COORD_MAPPER_CENTER_EN
  task automatic test_center();
    logic [LN*DW-1:0] r0;
    fixed_t l0, l1;
    set_cfg(25'sd262144, 25'sd0, 25'sd0);
    kick();
    collect(0, -1);
    l0 = -25'sd1048576; l1 = -25'sd786432;
    r0 = {l1, l0};
    n_checks++;
    if (rec[0][BW-1 -: LN*DW] !== r0 || rec[0][BW-LN*DW-1 -: DW] !== -25'sd524288) begin
      n_fail++; $display("FAIL center_beat0: got real=%h imag=%h want real=%h imag=%h",
                         rec[0][BW-1 -: LN*DW], rec[0][BW-LN*DW-1 -: DW], r0, -25'sd524288);
    end
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (rec[b] !== exp_beat(b, x_offset, y_offset, step)) begin
        n_fail++; $display("FAIL center_beat%0d: got %h want %h", b, rec[b], exp_beat(b, x_offset, y_offset, step));
      end
    end
  endtask
`endif

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_corner_frame();
    test_back_pressure();
    test_shadowing();
    test_reset_mid_frame();
    test_wrap();
`ifdef COORD_MAPPER_CENTER_EN
    test_center();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
